// File: rtl/pong_pkg.sv
// Shared definitions for the pong match sequencer: state codes, score type,
// serve directions and small constant helpers.
package pong_pkg;

  localparam int SCORE_W = 4;
  typedef logic [SCORE_W-1:0] score_t;
  localparam score_t SCORE_MAX = '1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic score_t sat_inc(input score_t s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Match sequencer bus: game-engine inputs on one side, ball-engine control
// and scoreboard/display outputs on the other.
interface match_ctrl_if;
  import pong_pkg::*;

  logic       tick;
  logic       start;
  logic       entropy;
  logic       p1_point;
  logic       p2_point;
  logic       run;
  logic       serve;
  logic       serve_dir;
  score_t     score_p1;
  score_t     score_p2;
  logic       game_over;
  logic       winner;
  logic       flash;
  logic [2:0] state;

  modport slave (
    input  tick, start, entropy, p1_point, p2_point,
    output run, serve, serve_dir, score_p1, score_p2, game_over, winner, flash, state
  );

  modport master (
    output tick, start, entropy, p1_point, p2_point,
    input  run, serve, serve_dir, score_p1, score_p2, game_over, winner, flash, state
  );

endinterface

// File: rtl/match_ctrl_tick_timer.sv
// Loadable down-counter advanced by the game tick; expire flags the tick on
// which the count leaves 1, so a load of N lasts exactly N ticks.
module tick_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == W'(1));

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: serve/play/point/game-over FSM with both scores.
// Define WIN_BY_TWO_EN to require a two-point lead to win (saturation-safe).
module match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_DELAY  = 1000,
  parameter int POINT_DELAY  = 500,
  parameter int FLASH_PERIOD = 250
) (
  input logic        clk,
  input logic        reset,
  match_ctrl_if.slave bus
);

  localparam int TIMER_W = $clog2(max3(SERVE_DELAY, POINT_DELAY, FLASH_PERIOD) + 1);
  localparam logic [TIMER_W-1:0] SERVE_T = TIMER_W'(SERVE_DELAY);
  localparam logic [TIMER_W-1:0] POINT_T = TIMER_W'(POINT_DELAY);
  localparam logic [TIMER_W-1:0] FLASH_T = TIMER_W'(FLASH_PERIOD);

  logic [2:0]         state, state_d;
  logic               run, run_d;
  logic               serve, serve_d;
  logic               serve_dir, serve_dir_d;
  score_t             score_p1, score_p1_d;
  score_t             score_p2, score_p2_d;
  logic               game_over, game_over_d;
  logic               winner, winner_d;
  logic               flash, flash_d;
  logic               start_q;
  logic               start_rise;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               expire;
  score_t             p1_next, p2_next;
  logic               p1_wins, p2_wins;

  tick_timer #(.W(TIMER_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .tick   (bus.tick),
    .load   (timer_load),
    .value  (timer_value),
    .expire (expire)
  );

  assign start_rise = bus.start & ~start_q;
  assign p1_next    = sat_inc(score_p1);
  assign p2_next    = sat_inc(score_p2);

`ifdef WIN_BY_TWO_EN
  // A saturated score can no longer grow its lead, so reaching 15 ahead by one also wins.
  assign p1_wins = (int'(p1_next) >= WIN_SCORE && int'(p1_next) >= int'(score_p2) + 2) ||
                   (p1_next == SCORE_MAX && p1_next > score_p2);
  assign p2_wins = (int'(p2_next) >= WIN_SCORE && int'(p2_next) >= int'(score_p1) + 2) ||
                   (p2_next == SCORE_MAX && p2_next > score_p1);
`else
  assign p1_wins = (int'(p1_next) == WIN_SCORE);
  assign p2_wins = (int'(p2_next) == WIN_SCORE);
`endif

  always_comb begin
    state_d     = state;
    run_d       = run;
    serve_d     = 1'b0;
    serve_dir_d = serve_dir;
    score_p1_d  = score_p1;
    score_p2_d  = score_p2;
    game_over_d = game_over;
    winner_d    = winner;
    flash_d     = flash;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_dir_d = bus.entropy;
          timer_load  = 1'b1;
          timer_value = SERVE_T;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (expire) begin
          serve_d = 1'b1;
          run_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.p1_point && bus.p2_point) begin
          run_d       = 1'b0;
          timer_load  = 1'b1;
          timer_value = POINT_T;
          state_d     = ST_POINT;
        end else if (bus.p1_point) begin
          run_d       = 1'b0;
          score_p1_d  = p1_next;
          serve_dir_d = DIR_RIGHT;
          timer_load  = 1'b1;
          if (p1_wins) begin
            game_over_d = 1'b1;
            winner_d    = 1'b0;
            timer_value = FLASH_T;
            state_d     = ST_OVER;
          end else begin
            timer_value = POINT_T;
            state_d     = ST_POINT;
          end
        end else if (bus.p2_point) begin
          run_d       = 1'b0;
          score_p2_d  = p2_next;
          serve_dir_d = DIR_LEFT;
          timer_load  = 1'b1;
          if (p2_wins) begin
            game_over_d = 1'b1;
            winner_d    = 1'b1;
            timer_value = FLASH_T;
            state_d     = ST_OVER;
          end else begin
            timer_value = POINT_T;
            state_d     = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (expire) begin
          timer_load  = 1'b1;
          timer_value = SERVE_T;
          state_d     = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          score_p1_d  = '0;
          score_p2_d  = '0;
          winner_d    = 1'b0;
          flash_d     = 1'b0;
          game_over_d = 1'b0;
          serve_dir_d = bus.entropy;
          timer_load  = 1'b1;
          timer_value = SERVE_T;
          state_d     = ST_SERVE;
        end else if (expire) begin
          flash_d     = ~flash;
          timer_load  = 1'b1;
          timer_value = FLASH_T;
        end
      end
      default: begin
        run_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      run       <= 1'b0;
      serve     <= 1'b0;
      serve_dir <= 1'b0;
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      flash     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_d;
      run       <= run_d;
      serve     <= serve_d;
      serve_dir <= serve_dir_d;
      score_p1  <= score_p1_d;
      score_p2  <= score_p2_d;
      game_over <= game_over_d;
      winner    <= winner_d;
      flash     <= flash_d;
      start_q   <= bus.start;
    end
  end

  assign bus.run       = run;
  assign bus.serve     = serve;
  assign bus.serve_dir = serve_dir;
  assign bus.score_p1  = score_p1;
  assign bus.score_p2  = score_p2;
  assign bus.game_over = game_over;
  assign bus.winner    = winner;
  assign bus.flash     = flash;
  assign bus.state     = state;

endmodule
